// File: rtl/f_pc_sequencer.sv
// Fetch-stage PC sequencer: owns the PC, picks the next fetch address from
// sequential, J/JAL, JR, branch and BEX sources. It holds a late redirect
// that arrives while fetch is stalled until the stall is released.
module f_pc_sequencer #(
  parameter int unsigned            PC_W     = 32,
  parameter int unsigned            TGT_W    = 27,
  parameter logic [PC_W-1:0]        RESET_PC = '0,
  parameter int unsigned            CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic [4:0]        opcode,
  input  logic [TGT_W-1:0]  target,
  input  logic              do_jr,
  input  logic [PC_W-1:0]   jr_target,
  input  logic              do_branch,
  input  logic [PC_W-1:0]   branch_target,
  input  logic              bex_jump,
  input  logic [PC_W-1:0]   bex_target,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   pc_plus1,
  output logic              squash,
  output logic              pending_valid,
  output logic [CNT_W-1:0]  redirect_count
);

  localparam logic [4:0]       OP_J   = 5'b00001;
  localparam logic [4:0]       OP_JAL = 5'b00011;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Sign-extend the J-type target field to a full PC.
  function automatic logic [PC_W-1:0] sext_target(input logic [TGT_W-1:0] t);
    logic [PC_W-1:0] r;
    r = {PC_W{t[TGT_W-1]}};
    r[TGT_W-1:0] = t;
    return r;
  endfunction

  // Increment that sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  logic              late;
  logic [PC_W-1:0]   late_target;
  logic              early;
  logic [PC_W-1:0]   pending_target;
  logic [PC_W-1:0]   next_pc;

  // Late redirect arbitration: the oldest resolving instruction type wins.
  always_comb begin
    late        = bex_jump | do_branch | do_jr;
    late_target = jr_target;
    if (bex_jump)       late_target = bex_target;
    else if (do_branch) late_target = branch_target;
  end

  assign early    = (opcode == OP_J) || (opcode == OP_JAL);
  assign pc_plus1 = pc + PC_W'(1);
  assign squash   = ~stall & (pending_valid | late);

  // Next PC when fetch advances; a held redirect outranks everything because
  // anything fetched since it resolved is wrong-path.
  always_comb begin
    next_pc = pc_plus1;
    if (pending_valid)  next_pc = pending_target;
    else if (late)      next_pc = late_target;
    else if (early)     next_pc = sext_target(target);
  end

  // PC, pending flag and redirect counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc             <= RESET_PC;
      pending_valid  <= 1'b0;
      redirect_count <= '0;
    end else begin
      if (stall) begin
        if (late && !pending_valid) pending_valid <= 1'b1;
      end else begin
        pc            <= next_pc;
        pending_valid <= 1'b0;
      end
      if (squash) redirect_count <= sat_inc(redirect_count);
    end
  end

  // Pending target capture; only meaningful while pending_valid is set.
  always_ff @(posedge clock) begin
    if (stall && late && !pending_valid) pending_target <= late_target;
  end

endmodule

// File: tb/tb_f_pc_sequencer.sv
// Directed plus randomized bench for f_pc_sequencer against a behavioural
// model of fetch redirection.
module tb_f_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h100;
  localparam int          CMAX   = 3;

  logic        clock = 1'b0;
  logic        reset, stall;
  logic [4:0]  opcode;
  logic [26:0] target;
  logic        do_jr, do_branch, bex_jump;
  logic [31:0] jr_target, branch_target, bex_target;
  logic [31:0] pc, pc_plus1;
  logic        squash, pending_valid;
  logic [1:0]  redirect_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  int          m_cnt;

  f_pc_sequencer #(.PC_W(32), .TGT_W(27), .RESET_PC(RST_PC), .CNT_W(2)) dut (
    .clock(clock), .reset(reset), .stall(stall), .opcode(opcode), .target(target),
    .do_jr(do_jr), .jr_target(jr_target), .do_branch(do_branch),
    .branch_target(branch_target), .bex_jump(bex_jump), .bex_target(bex_target),
    .pc(pc), .pc_plus1(pc_plus1), .squash(squash), .pending_valid(pending_valid),
    .redirect_count(redirect_count));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset = 0; stall = 0; opcode = 5'b0; target = '0;
    do_jr = 0; do_branch = 0; bex_jump = 0;
    jr_target = '0; branch_target = '0; bex_target = '0;
  endtask

  function automatic logic any_late();
    return bex_jump || do_branch || do_jr;
  endfunction

  function automatic logic [31:0] late_tgt();
    if (bex_jump) return bex_target;
    if (do_branch) return branch_target;
    return jr_target;
  endfunction

  // Compare every output against the model for the currently driven inputs.
  task automatic check_all(input string tag);
    logic exp_sq;
    exp_sq = !stall && (m_pend.size() > 0 || any_late());
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".pc_plus1"}, pc_plus1, m_pc + 32'd1);
    chk({tag, ".squash"}, {31'b0, squash}, {31'b0, exp_sq});
    chk({tag, ".pending"}, {31'b0, pending_valid}, {31'b0, m_pend.size() > 0});
    chk({tag, ".count"}, {30'b0, redirect_count}, 32'(m_cnt));
  endtask

  // Advance the model by one clock edge using the driven inputs.
  task automatic model_edge();
    if (reset) begin
      m_pc = RST_PC; m_pend.delete(); m_cnt = 0;
    end else if (!stall) begin
      if (m_pend.size() > 0 || any_late()) m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
      if (m_pend.size() > 0)            m_pc = m_pend.pop_front();
      else if (any_late())              m_pc = late_tgt();
      else if (opcode == 5'd1 || opcode == 5'd3)
        m_pc = (target >= 27'h400_0000) ? 32'(target) - 32'h0800_0000 : 32'(target);
      else                              m_pc = m_pc + 32'd1;
    end else if (any_late() && m_pend.size() == 0) begin
      m_pend.push_back(late_tgt());
    end
  endtask

  // Settle inputs, check, then clock.
  task automatic step(input string tag);
    #1;
    check_all(tag);
    @(posedge clock);
    model_edge();
    #1;
  endtask

  initial begin
    idle(); reset = 1;
    m_pc = '0; m_cnt = 0;
    @(posedge clock); model_edge(); #1;
    idle();
    // Reset state
    chk("rst.pc", pc, 32'h100);
    chk("rst.count", {30'b0, redirect_count}, 32'd0);
    step("rst");
    step("seq1"); step("seq2");
    chk("seq.pc", pc, 32'h103);

    // Move to 0x10 via JR, then JAL with negative target
    do_jr = 1; jr_target = 32'h10; step("jr10"); idle();
    chk("jr.pc", pc, 32'h10);
    opcode = 5'b00011; target = 27'h400_0000; step("jal"); idle();
    chk("jal.pc", pc, 32'hFC00_0000);
    chk("jal.count", {30'b0, redirect_count}, 32'd1);

    // BEX beats branch beats J
    opcode = 5'b00001; target = 27'h123; do_branch = 1; branch_target = 32'h40;
    bex_jump = 1; bex_target = 32'h80;
    #1; chk("prio.squash", {31'b0, squash}, 32'd1);
    step("prio"); idle();
    chk("prio.pc", pc, 32'h80);

    // Four-cycle stall with JR in cycle 2 and branch in cycle 3
    stall = 1; step("st1");
    do_jr = 1; jr_target = 32'h200; step("st2"); idle(); stall = 1;
    chk("st2.pend", {31'b0, pending_valid}, 32'd1);
    do_branch = 1; branch_target = 32'h300; step("st3"); idle(); stall = 1;
    step("st4"); idle();
    chk("st.hold", pc, 32'h80);
    do_branch = 1; branch_target = 32'h999; opcode = 5'b00001;
    #1; chk("rel.squash", {31'b0, squash}, 32'd1);
    step("rel"); idle();
    chk("rel.pc", pc, 32'h200);
    chk("rel.pend", {31'b0, pending_valid}, 32'd0);
    step("post");

    // Reset while a redirect is pending in a stall
    stall = 1; do_jr = 1; jr_target = 32'h500; step("pend500"); idle();
    reset = 1; stall = 1; bex_jump = 1; bex_target = 32'h777;
    @(posedge clock); model_edge(); #1; idle();
    chk("rstst.pc", pc, RST_PC);
    chk("rstst.pend", {31'b0, pending_valid}, 32'd0);
    #1; chk("rstst.squash", {31'b0, squash}, 32'd0);
    step("rstst"); 
    chk("rstst.next", pc, RST_PC + 32'd1);

    // Counter saturation: 1,2,3,3,3
    for (int i = 0; i < 5; i++) begin
      do_branch = 1; branch_target = 32'h1000 + 32'(i); step("sat"); idle();
      chk("sat.cnt", {30'b0, redirect_count}, (i < 3) ? 32'(i + 1) : 32'd3);
    end

    // PC wrap
    do_jr = 1; jr_target = 32'hFFFF_FFFF; step("wrapj"); idle();
    #1; chk("wrap.plus1", pc_plus1, 32'h0);
    step("wrap");
    chk("wrap.pc", pc, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      idle();
      reset     = ($urandom_range(0, 49) == 0);
      stall     = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: opcode = 5'b00001;
        1: opcode = 5'b00011;
        default: opcode = 5'($urandom);
      endcase
      target        = 27'($urandom);
      do_jr         = ($urandom_range(0, 5) == 0);
      do_branch     = ($urandom_range(0, 5) == 0);
      bex_jump      = ($urandom_range(0, 7) == 0);
      jr_target     = $urandom;
      branch_target = $urandom;
      bex_target    = $urandom;
      if (reset) begin
        @(posedge clock); model_edge(); #1;
      end else begin
        step("rnd");
      end
    end
    idle();
    #1; check_all("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
